// File: rtl/risc8_muldiv_seq.sv
// RISC8 multiply/divide sequencer: steps the ALU through INIT, NBITS
// iterations, optional RESTORE and two result-save cycles.
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   start, is_div        op request from decode (sampled in IDLE only)
//   divide_by_0          ALU zero-divisor flag, looked at in INIT only
//   abort                cancel request (honoured when RISC8_MULDIV_ABORT_EN
//                        is defined, otherwise ignored)
//   muldiv_op[5:0]       {div_restore,save1,save0,init,div,mul} to ALU
//   alu_add_sel          force ALU ADD (iterate/restore)
//   alu_thb_sel          force ALU pass-B (INIT divisor check)
//   wr_lo, wr_hi         result low/high register write strobes
//   busy, done, dz_err   stall, completion pulse, sticky divide-by-zero
//
// Config macro: RISC8_MULDIV_ABORT_EN enables the abort path.

module risc8_muldiv_seq #(
    parameter int NBITS = 8,
    parameter int CNT_W = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       is_div,
    input  logic       divide_by_0,
    input  logic       abort,
    output logic [5:0] muldiv_op,
    output logic       alu_add_sel,
    output logic       alu_thb_sel,
    output logic       wr_lo,
    output logic       wr_hi,
    output logic       busy,
    output logic       done,
    output logic       dz_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_ITER,
        S_RESTORE,
        S_SAVE0,
        S_SAVE1,
        S_DONE
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NBITS - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             op_div_q, op_div_d;
    logic             dz_q, dz_d;

    logic [5:0]       op_q, op_d;
    logic             add_q, add_d;
    logic             thb_q, thb_d;
    logic             lo_q, lo_d;
    logic             hi_q, hi_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

`ifdef RISC8_MULDIV_ABORT_EN
    logic abort_ok;
    // Abort only before the save cycles so result writes stay atomic.
    assign abort_ok = abort &&
                      (state_q == S_INIT || state_q == S_ITER ||
                       state_q == S_RESTORE);
`else
    logic unused_abort;
    assign unused_abort = abort;
`endif

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_div_d = op_div_q;
        dz_d     = dz_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_INIT;
                    op_div_d = is_div;
                    dz_d     = 1'b0;
                end
            end
            S_INIT: begin
                if (op_div_q && divide_by_0) begin
                    state_d = S_DONE;
                    dz_d    = 1'b1;
                end else begin
                    state_d = S_ITER;
                    cnt_d   = '0;
                end
            end
            S_ITER: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = op_div_q ? S_RESTORE : S_SAVE0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESTORE: state_d = S_SAVE0;
            S_SAVE0:   state_d = S_SAVE1;
            S_SAVE1:   state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
`ifdef RISC8_MULDIV_ABORT_EN
        if (abort_ok) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end
`endif
    end

    // Outputs decoded from the next state so they can be registered
    // and still line up with the state they describe.
    always_comb begin
        op_d   = 6'b000000;
        add_d  = 1'b0;
        thb_d  = 1'b0;
        lo_d   = 1'b0;
        hi_d   = 1'b0;
        busy_d = 1'b0;
        done_d = 1'b0;
        unique case (state_d)
            S_INIT: begin
                op_d   = 6'b000100;
                thb_d  = 1'b1;
                busy_d = 1'b1;
            end
            S_ITER: begin
                op_d   = op_div_d ? 6'b000010 : 6'b000001;
                add_d  = 1'b1;
                busy_d = 1'b1;
            end
            S_RESTORE: begin
                op_d   = 6'b100000;
                add_d  = 1'b1;
                busy_d = 1'b1;
            end
            S_SAVE0: begin
                op_d   = 6'b001000;
                lo_d   = 1'b1;
                busy_d = 1'b1;
            end
            S_SAVE1: begin
                op_d   = 6'b010000;
                hi_d   = 1'b1;
                busy_d = 1'b1;
            end
            S_DONE:  done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_div_q <= 1'b0;
            dz_q     <= 1'b0;
            op_q     <= 6'b000000;
            add_q    <= 1'b0;
            thb_q    <= 1'b0;
            lo_q     <= 1'b0;
            hi_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_div_q <= op_div_d;
            dz_q     <= dz_d;
            op_q     <= op_d;
            add_q    <= add_d;
            thb_q    <= thb_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign muldiv_op   = op_q;
    assign alu_add_sel = add_q;
    assign alu_thb_sel = thb_q;
    assign wr_lo       = lo_q;
    assign wr_hi       = hi_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign dz_err      = dz_q;

endmodule

// File: tb/tb_risc8_muldiv_seq.sv
// Self-checking bench for risc8_muldiv_seq: expected per-cycle outputs
// come from a cycle schedule built from the operation's rules.

module tb_risc8_muldiv_seq;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       is_div;
    logic       divide_by_0;
    logic       abort;
    logic [5:0] muldiv_op;
    logic       alu_add_sel;
    logic       alu_thb_sel;
    logic       wr_lo;
    logic       wr_hi;
    logic       busy;
    logic       done;
    logic       dz_err;

    int checks;
    int errors;

`ifdef RISC8_MULDIV_ABORT_EN
    localparam bit ABT = 1'b1;
`else
    localparam bit ABT = 1'b0;
`endif

    risc8_muldiv_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .is_div     (is_div),
        .divide_by_0(divide_by_0),
        .abort      (abort),
        .muldiv_op  (muldiv_op),
        .alu_add_sel(alu_add_sel),
        .alu_thb_sel(alu_thb_sel),
        .wr_lo      (wr_lo),
        .wr_hi      (wr_hi),
        .busy       (busy),
        .done       (done),
        .dz_err     (dz_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [12:0] obs();
        return {muldiv_op, alu_add_sel, alu_thb_sel,
                wr_lo, wr_hi, busy, done, dz_err};
    endfunction

    // Cycles from the start-sampled edge to the done pulse.
    function automatic int total(bit div, bit dz);
        if (div && dz) return 2;
        return div ? 13 : 12;
    endfunction

    // Expected outputs in cycle k after the start-sampled edge.
    function automatic logic [12:0] exp_vec(bit div, bit dz, int k);
        logic [5:0] op;
        logic add, thb, lo, hi, bsy, dn, dze;
        int s;
        op = '0; add = 0; thb = 0; lo = 0; hi = 0;
        bsy = 0; dn = 0;
        s = div ? 11 : 10;
        dze = (k >= 2) && div && dz;
        if (k == 1) begin
            op = 6'b000100; thb = 1; bsy = 1;
        end else if (div && dz) begin
            dn = (k == 2);
        end else if (k >= 2 && k <= 9) begin
            op = div ? 6'b000010 : 6'b000001;
            add = 1; bsy = 1;
        end else if (div && k == 10) begin
            op = 6'b100000; add = 1; bsy = 1;
        end else if (k == s) begin
            op = 6'b001000; lo = 1; bsy = 1;
        end else if (k == s + 1) begin
            op = 6'b010000; hi = 1; bsy = 1;
        end else if (k == s + 2) begin
            dn = 1;
        end
        return {op, add, thb, lo, hi, bsy, dn, dze};
    endfunction

    // One operation; abort pulsed in cycle ab_k (0 = never).
    // Call and return at a negedge with the DUT idle.
    task automatic run_op(input string nm, input bit div,
                          input bit dz, input int ab_k);
        int L, end_k, s;
        bit eff;
        logic [12:0] e;
        L = total(div, dz);
        s = div ? 11 : 10;
        eff = ABT && !(div && dz) && ab_k >= 1 && ab_k < s;
        end_k = eff ? ab_k : L;
        start = 1'b1;
        is_div = div;
        divide_by_0 = 1'($urandom);
        abort = 1'b0;
        for (int k = 1; k <= L + 1; k++) begin
            @(posedge clk);
            #1;
            start = (k <= end_k) ? 1'($urandom) : 1'b0;
            is_div = 1'($urandom);
            divide_by_0 = (k == 1) ? dz : 1'($urandom);
            abort = (k == ab_k);
            @(negedge clk);
            e = (eff && k > ab_k) ? 13'd0 : exp_vec(div, dz, k);
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL %s cyc%0d got=%b exp=%b",
                         nm, k, obs(), e);
            end
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        is_div = 1'b0;
        divide_by_0 = 1'b0;
        abort = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (obs() !== 13'd0) begin
            errors++;
            $display("FAIL reset_hold got=%b exp=0", obs());
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (obs() !== 13'd0) begin
            errors++;
            $display("FAIL reset_idle got=%b exp=0", obs());
        end
    endtask

    task automatic test_mul();
        run_op("mul", 1'b0, 1'b0, 0);
        run_op("mul_dz_ignored", 1'b0, 1'b1, 0);
    endtask

    task automatic test_div();
        logic [7:0] a, b;
        a = 8'hC8;
        b = 8'h07;
        if (a / b != 8'h1C || a % b != 8'h04)
            $display("note: reference quotient differs");
        run_op("div", 1'b1, 1'b0, 0);
    endtask

    task automatic test_div_by_zero();
        run_op("div_by_0", 1'b1, 1'b1, 0);
        checks++;
        if (dz_err !== 1'b1) begin
            errors++;
            $display("FAIL dz_sticky got=%b exp=1", dz_err);
        end
        run_op("dz_cleared", 1'b0, 1'b0, 0);
    endtask

    task automatic test_back_to_back();
        bit d;
        int L, p;
        d = 1'($urandom);
        L = total(d, 1'b0);
        start = 1'b1;
        is_div = d;
        divide_by_0 = 1'b0;
        for (int k = 1; k <= 2 * (L + 1); k++) begin
            @(negedge clk);
            p = (k - 1) % (L + 1) + 1;
            checks++;
            if (obs() !== exp_vec(d, 1'b0, p)) begin
                errors++;
                $display("FAIL back_to_back cyc%0d got=%b exp=%b",
                         k, obs(), exp_vec(d, 1'b0, p));
            end
        end
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        start = 1'b1;
        is_div = 1'b0;
        divide_by_0 = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (6) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs() !== 13'd0) begin
            errors++;
            $display("FAIL async_reset got=%b exp=0", obs());
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op("after_reset", 1'b1, 1'b0, 0);
    endtask

    task automatic test_abort();
        run_op("abort_iter", 1'b0, 1'b0, 5);
        run_op("abort_save0", 1'b0, 1'b0, 10);
        run_op("abort_restore", 1'b1, 1'b0, 10);
    endtask

    task automatic test_random();
        bit d, z;
        int ab;
        for (int i = 0; i < 25; i++) begin
            d = 1'($urandom);
            z = ($urandom_range(0, 3) == 0);
            ab = ($urandom_range(0, 2) == 0) ?
                 int'($urandom_range(1, 14)) : 0;
            run_op("random", d, z, ab);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_mul();
        test_div();
        test_div_by_zero();
        test_back_to_back();
        test_async_reset();
        test_abort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
